// File: rtl/phase_ramp.sv
// Per-packet phase-ramp tagger feeding the CORDIC rotator: emits {phase, q, i} per input sample.
// Optional build macro PHASE_DITHER_EN adds an LFSR low-byte dither to the output phase only.
//
//   state     | meaning
//   ST_IDLE   | waiting for first beat of a packet (beat phase 0, pending increment applied)
//   ST_ACTIVE | inside a packet, beat phase = accumulated phase
module phase_ramp #(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [2*WIDTH-1:0] cfg_data,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic [2*WIDTH-1:0] s_data,
   input  logic               s_last,
   output logic               m_valid,
   input  logic               m_ready,
   output logic [4*WIDTH-1:0] m_data,
   output logic               m_last
);

   localparam int PW = 2 * WIDTH;
   localparam int BW = 4 * WIDTH;

   typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

   state_t         state_q, state_d;
   logic [PW-1:0]  inc_q, inc_d;
   logic [PW-1:0]  pend_q, pend_d;
   logic           pend_valid_q, pend_valid_d;
   logic [PW-1:0]  acc_q, acc_d;

   logic           out_valid_q, out_valid_d;
   logic [BW-1:0]  out_data_q, out_data_d;
   logic           out_last_q, out_last_d;
   logic           skid_valid_q, skid_valid_d;
   logic [BW-1:0]  skid_data_q, skid_data_d;
   logic           skid_last_q, skid_last_d;
   logic           s_ready_q, s_ready_d;

   logic           in_fire;
   logic           cfg_fire;
   logic           out_load;
   logic [PW-1:0]  inc_eff;
   logic [PW-1:0]  beat_phase;
   logic [PW-1:0]  out_phase;
   logic [BW-1:0]  beat_data;

   assign in_fire  = s_valid && s_ready_q;
   assign cfg_fire = cfg_valid && !pend_valid_q;
   assign out_load = !out_valid_q || m_ready;

   assign cfg_ready = !pend_valid_q;
   assign s_ready   = s_ready_q;
   assign m_valid   = out_valid_q;
   assign m_data    = out_data_q;
   assign m_last    = out_last_q;

`ifdef PHASE_DITHER_EN
   logic [15:0] lfsr_q, lfsr_d;
   logic        lfsr_fb;

   // x^16+x^14+x^13+x^11+1, right-shifting Fibonacci form
   assign lfsr_fb   = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
   assign lfsr_d    = in_fire ? {lfsr_fb, lfsr_q[15:1]} : lfsr_q;
   assign out_phase = beat_phase + {{(PW-8){1'b0}}, lfsr_q[7:0]};

   always_ff @(posedge clk) begin
      if (reset) lfsr_q <= 16'hACE1;
      else       lfsr_q <= lfsr_d;
   end
`else
   assign out_phase = beat_phase;
`endif

   assign beat_data = {out_phase, s_data};

   always_comb begin
      state_d      = state_q;
      inc_d        = inc_q;
      pend_d       = pend_q;
      pend_valid_d = pend_valid_q;
      acc_d        = acc_q;
      beat_phase   = '0;
      inc_eff      = pend_valid_q ? pend_q : inc_q;
      case (state_q)
         ST_IDLE: begin
            if (in_fire) begin
               if (pend_valid_q) begin
                  inc_d        = pend_q;
                  pend_valid_d = 1'b0;
               end
               acc_d   = inc_eff;
               state_d = s_last ? ST_IDLE : ST_ACTIVE;
            end
         end
         ST_ACTIVE: begin
            beat_phase = acc_q;
            if (in_fire) begin
               acc_d = acc_q + inc_q;
               if (s_last) state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Applied after the packet-start update so a same-cycle config lands for the next packet
      if (cfg_fire) begin
         pend_d       = cfg_data;
         pend_valid_d = 1'b1;
      end
   end

   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_last_d   = out_last_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      skid_last_d  = skid_last_q;
      if (out_load) begin
         if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_data_d   = skid_data_q;
            out_last_d   = skid_last_q;
            skid_valid_d = 1'b0;
         end else if (in_fire) begin
            out_valid_d = 1'b1;
            out_data_d  = beat_data;
            out_last_d  = s_last;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (in_fire) begin
         skid_valid_d = 1'b1;
         skid_data_d  = beat_data;
         skid_last_d  = s_last;
      end
      s_ready_d = !skid_valid_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         inc_q        <= '0;
         pend_q       <= '0;
         pend_valid_q <= 1'b0;
         acc_q        <= '0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_last_q   <= 1'b0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         skid_last_q  <= 1'b0;
         s_ready_q    <= 1'b1;
      end else begin
         state_q      <= state_d;
         inc_q        <= inc_d;
         pend_q       <= pend_d;
         pend_valid_q <= pend_valid_d;
         acc_q        <= acc_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_last_q   <= out_last_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         skid_last_q  <= skid_last_d;
         s_ready_q    <= s_ready_d;
      end
   end

endmodule

// File: tb/tb_phase_ramp.sv
// Directed bench for phase_ramp: ramp values, wrap, config timing, backpressure, reset, skid.
// Expected dither (when PHASE_DITHER_EN is defined) comes from an independent LFSR model.
module tb_phase_ramp;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cfg_valid = 1'b0;
   logic        cfg_ready;
   logic [31:0] cfg_data = '0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [31:0] s_data = '0;
   logic        s_last = 1'b0;
   logic        m_valid;
   logic        m_ready = 1'b1;
   logic [63:0] m_data;
   logic        m_last;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [15:0] tb_lfsr = 16'hACE1;
   logic [63:0] last_exp;

   phase_ramp #(.WIDTH(16)) dut (
      .clk(clk), .reset(reset),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] dith();
      logic [31:0] d;
      d = 32'h0;
`ifdef PHASE_DITHER_EN
      d = {24'h0, tb_lfsr[7:0]};
      tb_lfsr = {tb_lfsr[0] ^ tb_lfsr[2] ^ tb_lfsr[3] ^ tb_lfsr[5], tb_lfsr[15:1]};
`endif
      return d;
   endfunction

   task automatic cfg(input logic [31:0] val);
      chk("cfg_rdy_before", cfg_ready, 1'b1);
      cfg_valid = 1'b1;
      cfg_data  = val;
      tick();
      cfg_valid = 1'b0;
      chk("cfg_rdy_after", cfg_ready, 1'b0);
   endtask

   task automatic beat(input string tag, input logic [31:0] ph, input logic last,
                       input logic [15:0] iv, input logic [15:0] qv);
      logic [31:0] eph;
      chk({tag, "_srdy"}, s_ready, 1'b1);
      s_valid = 1'b1;
      s_data  = {qv, iv};
      s_last  = last;
      tick();
      s_valid = 1'b0;
      s_last  = 1'b0;
      eph = ph + dith();
      last_exp = {eph, qv, iv};
      chk(tag, {m_valid, m_last, m_data}, {1'b1, last, eph, qv, iv});
   endtask

   initial begin
      logic [31:0] ph;
      logic [63:0] exp_b;

      // reset values while reset is held
      tick();
      tick();
      chk("rst_outs", {m_valid, m_last, m_data, s_ready, cfg_ready}, {1'b0, 1'b0, 64'h0, 1'b1, 1'b1});
      reset = 1'b0;
      tb_lfsr = 16'hACE1;

      // 4-beat ramp at 0x2000_0000
      cfg(32'h2000_0000);
      for (int k = 0; k < 4; k++) begin
         ph = 32'(k) * 32'h2000_0000;
         beat($sformatf("p4_b%0d", k), ph, k == 3, 16'd100, 16'hFF9C);
         if (k == 0) chk("cfg_rdy_applied", cfg_ready, 1'b1);
      end
      tick();
      chk("p4_idle", m_valid, 1'b0);

      // 9-beat packet wraps on beat 9
      for (int k = 0; k < 9; k++) begin
         ph = 32'(k) * 32'h2000_0000;
         beat($sformatf("p9_b%0d", k), ph, k == 8, 16'(k), 16'(k + 50));
      end
      tick();

      // config mid-packet; second offer refused until next packet starts
      beat("mid_b0", 32'h0, 1'b0, 16'h1111, 16'h2222);
      cfg(32'h0100_0000);
      cfg_valid = 1'b1;
      cfg_data  = 32'h0F00_0000;
      tick();
      cfg_valid = 1'b0;
      chk("cfg_refused", cfg_ready, 1'b0);
      for (int k = 1; k < 4; k++) begin
         ph = 32'(k) * 32'h2000_0000;
         beat($sformatf("mid_b%0d", k), ph, k == 3, 16'h1111, 16'h2222);
      end
      for (int k = 0; k < 3; k++) begin
         ph = 32'(k) * 32'h0100_0000;
         beat($sformatf("new_b%0d", k), ph, k == 2, 16'h3333, 16'h4444);
         if (k == 0) chk("cfg_rdy_new_pkt", cfg_ready, 1'b1);
      end
      tick();

      // random backpressure over 100 beats of 8-beat packets
      fork
         begin : prod
            int guard;
            logic acc;
            for (int j = 0; j < 100; j++) begin
               s_valid = 1'b1;
               s_data  = {16'h8000 | 16'(j), 16'(j)};
               s_last  = (j % 8 == 7) || (j == 99);
               guard   = 0;
               do begin
                  acc = s_ready;
                  tick();
                  guard++;
               end while (!acc && guard < 1000);
            end
            s_valid = 1'b0;
            s_last  = 1'b0;
         end
         begin : cons
            int rcv;
            int cyc;
            logic stall;
            logic [63:0] hold_d;
            logic hold_l;
            logic [31:0] eph;
            rcv = 0;
            cyc = 0;
            while (rcv < 100 && cyc < 3000) begin
               m_ready = 1'($urandom_range(0, 1));
               if (m_valid && m_ready) begin
                  eph = 32'(rcv % 8) * 32'h0100_0000 + dith();
                  chk($sformatf("rnd_d%0d", rcv), m_data, {eph, 16'h8000 | 16'(rcv), 16'(rcv)});
                  chk($sformatf("rnd_l%0d", rcv), m_last, (rcv % 8 == 7) || (rcv == 99));
                  rcv++;
               end
               stall  = m_valid && !m_ready;
               hold_d = m_data;
               hold_l = m_last;
               tick();
               cyc++;
               if (stall) chk("rnd_hold", {m_valid, m_last, m_data}, {1'b1, hold_l, hold_d});
            end
            chk("rnd_count", rcv, 100);
            m_ready = 1'b1;
         end
      join
      tick();
      tick();
      chk("rnd_no_extra", m_valid, 1'b0);

      // reset on beat 3 of an 8-beat packet with a config pending
      beat("rst_b0", 32'h0, 1'b0, 16'h0A0A, 16'h0B0B);
      cfg(32'h0300_0000);
      beat("rst_b1", 32'h0100_0000, 1'b0, 16'h0A0A, 16'h0B0B);
      s_valid = 1'b1;
      s_data  = 32'h0B0B_0A0A;
      reset   = 1'b1;
      tick();
      s_valid = 1'b0;
      reset   = 1'b0;
      tb_lfsr = 16'hACE1;
      chk("rst_mid_outs", {m_valid, m_data, s_ready, cfg_ready}, {1'b0, 64'h0, 1'b1, 1'b1});
      for (int k = 0; k < 3; k++)
         beat($sformatf("post_rst_b%0d", k), 32'h0, k == 2, 16'h0C0C, 16'h0D0D);
      tick();

      // skid: stalled second beat drops s_ready, then drains
      m_ready = 1'b0;
      beat("skid_a", 32'h0, 1'b0, 16'h00AA, 16'h00BB);
      s_valid = 1'b1;
      s_data  = 32'h00DD_00CC;
      s_last  = 1'b1;
      tick();
      s_valid = 1'b0;
      s_last  = 1'b0;
      exp_b = {32'h0 + dith(), 32'h00DD_00CC};
      chk("skid_srdy_low", s_ready, 1'b0);
      chk("skid_hold_a", {m_valid, m_last, m_data}, {1'b1, 1'b0, last_exp});
      m_ready = 1'b1;
      tick();
      chk("skid_out_b", {m_valid, m_last, m_data}, {1'b1, 1'b1, exp_b});
      chk("skid_srdy_high", s_ready, 1'b1);
      tick();
      chk("skid_empty", m_valid, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/phase_ramp.md
# phase_ramp

Per-packet phase-ramp generator that sits directly upstream of the CORDIC rotator. It accepts an IQ sample stream, tags each sample with an accumulated phase (sample index × programmed increment, restarted at every packet), and emits the `{phase, q, i}` beat the rotator consumes for carrier-frequency-offset correction. The increment is programmed through a separate config handshake and takes effect only at packet boundaries.

## Interface
- `WIDTH`, 16, width of each I/Q component; phase is `2*WIDTH` bits. Phase units: full scale `2^(2*WIDTH)` = 2π, signed, MSB weight −π.
- `clk`  input  1  clock
- `reset`  input  1  reset, synchronous, active-high
- `cfg_valid`  input  1  new phase increment offered
- `cfg_ready`  output  1  pending-increment slot empty
- `cfg_data`  input  2*WIDTH  signed phase increment per sample
- `s_valid`  input  1  input sample valid
- `s_ready`  output  1  input accepted when high with `s_valid`
- `s_data`  input  2*WIDTH  `{q[2W-1:W], i[W-1:0]}`, signed
- `s_last`  input  1  final sample of packet
- `m_valid`  output  1  output beat valid
- `m_ready`  input  1  downstream ready
- `m_data`  output  4*WIDTH  `{phase[4W-1:2W], q[2W-1:W], i[W-1:0]}`
- `m_last`  output  1  final beat of packet

## Operation
- Registers: `inc` (active increment), `pend` + `pend_valid` (single-entry pending increment), `acc` (next phase), `state` ∈ {IDLE, ACTIVE}.
- Config: `cfg_ready = !pend_valid`. On `cfg_valid && cfg_ready`: `pend <= cfg_data`, `pend_valid <= 1`. Accepted at any time, never applied mid-packet.
- IDLE, input beat accepted (first beat of packet):
  - Beat phase = 0.
  - `inc_eff = pend_valid ? pend : inc`. If `pend_valid`: `inc <= pend`, `pend_valid <= 0`.
  - `acc <= inc_eff`.
  - `state <= s_last ? IDLE : ACTIVE`. A single-beat packet stays in IDLE.
- ACTIVE, input beat accepted:
  - Beat phase = `acc`; `acc <= acc + inc`. Modulo `2^(2W)`, natural wrap, no saturation.
  - `s_last` moves the state to IDLE.
- Simultaneous config accept and first-beat accept in IDLE: the first beat uses the old `pend`/`inc` selection. The newly accepted `cfg_data` lands in `pend` and applies at the next packet. If `pend_valid` was 1 that cycle, `cfg_ready` was 0, so no conflict exists.
- I/Q pass through unmodified. `m_last` is `s_last` delayed with its beat.
- Output path: registered output stage plus a one-entry skid buffer. `s_ready` is registered and equals "skid empty", giving full throughput with no combinational `m_ready`→`s_ready` path.
- While `m_valid && !m_ready`, `m_data` and `m_last` hold stable.
- Reset mid-packet: all in-flight beats are dropped, `state` returns to IDLE, and `pend_valid` clears. The next accepted beat is treated as a packet start.

## Timing
- Latency: 1 cycle from input accept to `m_valid` when output is empty/draining.
- Throughput: 1 beat/cycle with `m_ready` held high.
- Backpressure: the first stalled beat goes into the skid. `s_ready` drops the following cycle and rises one cycle after the skid drains.
- Reset values: `m_valid=0`, `m_data=0`, `m_last=0`, `s_ready=1`, `cfg_ready=1`, `inc=0`, `acc=0`, `pend_valid=0`, `state=IDLE`. Outputs take these values in the cycle after `reset` is sampled high and hold them while it stays high.

## Configuration
- `PHASE_DITHER_EN` defined:
  - A 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) is seeded `16'hACE1` on reset and advances once per accepted input beat.
  - Output phase = beat phase + zero-extended `lfsr[7:0]`, modulo `2^(2W)`, which decorrelates downstream phase-quantisation error.
  - `acc` itself is never dithered.
- `PHASE_DITHER_EN` undefined: no LFSR is built and output phase equals beat phase exactly.

## Test plan
- Config `inc=32'h2000_0000`, then a 4-beat packet with `m_ready=1`, i=100, q=−100 → phases 0, 0x2000_0000, 0x4000_0000, 0x6000_0000; IQ unchanged; `m_last` on beat 4 only; each output 1 cycle after input.
- Same increment, 9-beat packet → beat 8 phase 0xE000_0000, beat 9 phase 0x0000_0000 (wrap).
- Mid-packet config `inc=32'h0100_0000` during a 4-beat packet at `inc=32'h2000_0000` → current packet keeps the 0x2000_0000 steps; next packet 0, 0x0100_0000, 0x0200_0000. A second config is refused (`cfg_ready=0`) until the next packet starts.
- Random `m_ready` (50%) over 100 beats of 8-beat packets → no beats lost or duplicated, `m_data` stable while stalled, phase sequence identical to the no-stall run.
- Reset asserted on beat 3 of an 8-beat packet → `m_valid=0` the next cycle; the following packet's first phase is 0 and its increment is 0 unless reconfigured.
- With `PHASE_DITHER_EN` and `inc=0` → first beat phase = `16'hACE1[7:0]` = 0xE1, subsequent phases follow the LFSR low byte.
